if_id_stage: RTL and testbench
==============================

IF_ID_STAGE -- requirements
Module: if_id_stage

Interface
REQ-001 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-002 SHALL have port reset  input  1  asynchronous active-low reset; reset=0 forces reset state immediately.
REQ-003 SHALL have port pc_in  input  8  fetch address, driven by the PC stage output.
REQ-004 SHALL have port pc_cout  input  1  carry from the PC offset adder; 1 marks the fetch address as wrapped.
REQ-005 SHALL have port stall  input  1  hold the IF/ID register contents this cycle.
REQ-006 SHALL have port flush  input  1  replace the next IF/ID register contents with a bubble.
REQ-007 SHALL have port prog_we  input  1  instruction-memory write enable.
REQ-008 SHALL have port prog_addr  input  8  instruction-memory write address.
REQ-009 SHALL have port prog_data  input  16  instruction-memory write data.
REQ-010 SHALL have port instr  output  16  registered instruction for decode.
REQ-011 SHALL have port pc_out  output  8  registered address of instr.
REQ-012 SHALL have port valid  output  1  instr/pc_out hold a real instruction.
REQ-013 SHALL have port branch_sel  output  1  select input for the PC stage mux.
REQ-014 SHALL have port branch_off  output  8  offset input for the PC stage.
REQ-015 SHALL have port halted  output  1  high while the FSM is in HALT.
REQ-016 SHALL have port wrap_err  output  1  sticky wrapped-fetch flag.
REQ-017 SHALL have port instr_count  output  16  count of instructions issued valid.

Function
REQ-018 SHALL contain a 256x16 instruction memory: synchronous write on prog_we; synchronous read at pc_in; memory contents not reset.
REQ-019 SHALL return old data on a same-cycle write and read of one address (read-before-write).
REQ-020 SHALL implement FSM states BOOT, RUN and HALT; reset enters BOOT.
REQ-021 SHALL move BOOT->RUN after exactly one clock; in BOOT valid stays 0, giving the first memory read a cycle.
REQ-022 SHALL, in RUN with stall=0 and flush=0, load instr=mem[pc_in of previous cycle], pc_out=previous pc_in, valid=1; one-cycle latency.
REQ-023 SHALL, in RUN with stall=1 and flush=0, hold instr, pc_out, valid and instr_count unchanged.
REQ-024 SHALL give flush priority over stall: flush=1 loads valid=0, instr=16'h0000, pc_out unchanged.
REQ-025 SHALL drive branch_sel = valid AND instr[15:12]==4'hC, combinationally from registered state; branch_off = instr[7:0].
REQ-026 SHALL move RUN->HALT on the edge after a valid instruction with instr[15:12]==4'hF is loaded; that instruction stays valid one cycle, then valid=0.
REQ-027 SHALL keep HALT until reset; in HALT ignore stall, flush and pc_in; keep branch_sel=0 and instr_count frozen; prog_we writes still take effect.
REQ-028 SHALL set wrap_err when pc_cout=1 in the same cycle RUN loads a new valid instruction; wrap_err clears only on reset.
REQ-029 SHALL increment instr_count on each edge that loads valid=1, saturating at 16'hFFFF.

Reset
REQ-030 SHALL, while reset=0, force instr=16'h0000, pc_out=8'h00, valid=0, branch_sel=0, branch_off=8'h00, halted=0, wrap_err=0, instr_count=0, state BOOT.
REQ-031 SHALL, on reset asserted mid-operation, abandon any in-flight instruction; after release, restart with the BOOT bubble.

Verification
REQ-032 Bench SHALL: preload mem[0..3]={1111,2222,C005,3333}, release reset, sweep pc_in 0,1,2 -> valid first high 2 cycles after release with instr=1111, pc_out=00; at pc_out=02 branch_sel=1, branch_off=05.
REQ-033 Bench SHALL: assert stall 3 cycles during streaming -> instr/pc_out/instr_count unchanged; assert stall and flush together -> next valid=0, instr=0000.
REQ-034 Bench SHALL: fetch F000 at address 10 -> valid=1 for one cycle with instr=F000, then halted=1, valid=0; toggling stall/flush/pc_in for 5 cycles changes nothing.
REQ-035 Bench SHALL: pulse pc_cout=1 on one valid load -> wrap_err=1 and stays 1 until reset.
REQ-036 Bench SHALL: write mem[20]=ABCD while reading address 20 with old value 1234 -> instr=1234; next read of 20 -> ABCD.
REQ-037 Bench SHALL: assert reset=0 between clock edges mid-stream -> all outputs reach reset values without a clock edge; instr_count=0.

Source files
------------

// File: rtl/if_id_stage.sv
// IF/ID pipeline stage: 256x16 instruction memory with a registered read,
// the IF/ID register, a BOOT/RUN/HALT sequencer and status counters.
module if_id_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  pc_in,
  input  logic        pc_cout,
  input  logic        stall,
  input  logic        flush,
  input  logic        prog_we,
  input  logic [7:0]  prog_addr,
  input  logic [15:0] prog_data,
  output logic [15:0] instr,
  output logic [7:0]  pc_out,
  output logic        valid,
  output logic        branch_sel,
  output logic [7:0]  branch_off,
  output logic        halted,
  output logic        wrap_err,
  output logic [15:0] instr_count
);

  typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

  state_t      state, state_next;
  logic [15:0] mem [256];
  logic [15:0] rd_data;
  logic [7:0]  rd_pc;
  logic        load, bubble, drop;

  // Read-before-write: rd_data samples the array before this edge's write lands.
  always_ff @(posedge clk) begin
    if (prog_we) mem[prog_addr] <= prog_data;
    rd_data <= mem[pc_in];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= BOOT;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    bubble     = 1'b0;
    drop       = 1'b0;
    case (state)
      BOOT: state_next = RUN;
      RUN: begin
        // A loaded halt instruction wins over stall and flush on the next edge.
        if (valid && instr[15:12] == 4'hF) begin
          state_next = HALT;
          drop       = 1'b1;
        end else if (flush) begin
          bubble = 1'b1;
        end else if (!stall) begin
          load = 1'b1;
        end
      end
      HALT:    state_next = HALT;
      default: state_next = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr       <= '0;
      pc_out      <= '0;
      valid       <= 1'b0;
      wrap_err    <= 1'b0;
      instr_count <= '0;
      rd_pc       <= '0;
    end else begin
      rd_pc <= pc_in;
      if (load) begin
        instr  <= rd_data;
        pc_out <= rd_pc;
        valid  <= 1'b1;
        if (instr_count != '1) instr_count <= instr_count + 16'd1;
        if (pc_cout) wrap_err <= 1'b1;
      end else if (bubble) begin
        instr <= '0;
        valid <= 1'b0;
      end else if (drop) begin
        valid <= 1'b0;
      end
    end
  end

  assign branch_sel = valid && (instr[15:12] == 4'hC);
  assign branch_off = instr[7:0];
  assign halted     = (state == HALT);

endmodule

// File: tb/tb_if_id_stage.sv
// Randomized scoreboard bench for if_id_stage against a behavioural pipeline model.
module tb_if_id_stage;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  pc_in = '0;
  logic        pc_cout = 1'b0, stall = 1'b0, flush = 1'b0, prog_we = 1'b0;
  logic [7:0]  prog_addr = '0;
  logic [15:0] prog_data = '0;
  logic [15:0] instr, instr_count;
  logic [7:0]  pc_out, branch_off;
  logic        valid, branch_sel, halted, wrap_err;

  int errors = 0;
  int checks = 0;

  if_id_stage dut (
    .clk(clk), .reset(reset), .pc_in(pc_in), .pc_cout(pc_cout), .stall(stall),
    .flush(flush), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .instr(instr), .pc_out(pc_out), .valid(valid), .branch_sel(branch_sel),
    .branch_off(branch_off), .halted(halted), .wrap_err(wrap_err),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  typedef struct { logic [15:0] instr; logic [7:0] pc; int cnt; } exp_t;
  exp_t q[$];

  // Model: memory array, last fetched word, architectural IF/ID view.
  logic [15:0] m_mem [256];
  logic [15:0] m_rd, m_instr;
  logic [7:0]  m_rdpc, m_pc;
  bit          m_valid, m_boot, m_halt, m_wrap;
  int          m_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_instr = '0; m_pc = '0; m_valid = 0; m_boot = 1; m_halt = 0; m_wrap = 0; m_cnt = 0;
  endtask

  function automatic logic [15:0] rnd_word();
    logic [15:0] w;
    w = 16'($urandom);
    if (w[15:12] == 4'hF) w[15:12] = 4'h7;
    return w;
  endfunction

  task automatic status();
    chk("valid", 32'(valid), 32'(m_valid));
    chk("halted", 32'(halted), 32'(m_halt));
    chk("wrap_err", 32'(wrap_err), 32'(m_wrap));
    chk("instr_count", 32'(instr_count), 32'(m_cnt));
    chk("instr", 32'(instr), 32'(m_instr));
    chk("pc_out", 32'(pc_out), 32'(m_pc));
    chk("branch_sel", 32'(branch_sel), 32'(m_valid && m_instr[15:12] == 4'hC));
    chk("branch_off", 32'(branch_off), 32'(m_instr[7:0]));
  endtask

  task automatic cyc(input logic [7:0] pc, input bit cout, input bit st, input bit fl,
                     input bit we, input logic [7:0] wa, input logic [15:0] wd);
    exp_t e;
    pc_in = pc; pc_cout = cout; stall = st; flush = fl;
    prog_we = we; prog_addr = wa; prog_data = wd;
    @(posedge clk);
    if (!reset) model_reset();
    else if (m_boot) m_boot = 0;
    else if (!m_halt) begin
      if (m_valid && m_instr[15:12] == 4'hF) begin
        m_halt = 1; m_valid = 0;
      end else if (fl) begin
        m_valid = 0; m_instr = '0;
      end else if (!st) begin
        m_instr = m_rd; m_pc = m_rdpc; m_valid = 1;
        if (m_cnt < 65535) m_cnt++;
        if (cout) m_wrap = 1;
        e.instr = m_instr; e.pc = m_pc; e.cnt = m_cnt;
        q.push_back(e);
      end
    end
    m_rd = m_mem[pc];
    m_rdpc = pc;
    if (we) m_mem[wa] = wd;
    @(negedge clk);
    status();
  endtask

  task automatic idle(input logic [7:0] pc);
    cyc(pc, 0, 0, 0, 0, 8'h00, 16'h0000);
  endtask

  task automatic async_reset_check();
    #2 reset = 1'b0;
    #1;
    chk("rst_instr", 32'(instr), 32'h0);
    chk("rst_pc_out", 32'(pc_out), 32'h0);
    chk("rst_valid", 32'(valid), 32'h0);
    chk("rst_branch_sel", 32'(branch_sel), 32'h0);
    chk("rst_branch_off", 32'(branch_off), 32'h0);
    chk("rst_halted", 32'(halted), 32'h0);
    chk("rst_wrap_err", 32'(wrap_err), 32'h0);
    chk("rst_instr_count", 32'(instr_count), 32'h0);
    model_reset();
    @(negedge clk);
  endtask

  // Monitor: every newly issued instruction is matched against the scoreboard.
  initial begin
    logic [15:0] last;
    exp_t e;
    last = '0;
    forever begin
      @(negedge clk);
      if (valid === 1'b1 && instr_count !== last) begin
        if (q.size() == 0) begin
          chk("sb_unexpected_issue", 32'(instr_count), 32'h0);
        end else begin
          e = q.pop_front();
          chk("sb_instr", 32'(instr), 32'(e.instr));
          chk("sb_pc_out", 32'(pc_out), 32'(e.pc));
          chk("sb_count", 32'(instr_count), 32'(e.cnt));
          chk("sb_branch_sel", 32'(branch_sel), 32'(e.instr[15:12] == 4'hC));
          chk("sb_branch_off", 32'(branch_off), 32'(e.instr[7:0]));
        end
      end
      last = instr_count;
    end
  end

  initial begin
    model_reset();
    @(negedge clk);
    for (int unsigned a = 0; a < 256; a++) cyc(8'h00, 0, 0, 0, 1, 8'(a), rnd_word());
    cyc(8'h00, 0, 0, 0, 1, 8'd0, 16'h1111);
    cyc(8'h00, 0, 0, 0, 1, 8'd1, 16'h2222);
    cyc(8'h00, 0, 0, 0, 1, 8'd2, 16'hC005);
    cyc(8'h00, 0, 0, 0, 1, 8'd3, 16'h3333);
    cyc(8'h00, 0, 0, 0, 1, 8'd10, 16'hF000);
    cyc(8'h00, 0, 0, 0, 1, 8'd20, 16'h1234);

    reset = 1'b1;
    for (int i = 0; i < 7; i++) idle(8'(i));
    for (int i = 0; i < 3; i++) cyc(8'd7, 0, 1, 0, 0, 8'h00, 16'h0000);
    idle(8'd8);
    cyc(8'd9, 0, 1, 1, 0, 8'h00, 16'h0000);
    idle(8'd12);
    idle(8'd13);

    for (int i = 0; i < 150; i++)
      cyc(8'($urandom_range(30, 250)), 0, $urandom_range(0, 3) == 0,
          $urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1,
          8'($urandom_range(30, 255)), rnd_word());

    idle(8'd50);
    idle(8'd51);
    cyc(8'd52, 1, 0, 0, 0, 8'h00, 16'h0000);
    for (int i = 0; i < 4; i++) idle(8'(53 + i));

    cyc(8'd20, 0, 0, 0, 1, 8'd20, 16'hABCD);
    idle(8'd20);
    idle(8'd21);
    idle(8'd22);

    async_reset_check();
    idle(8'd0);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) idle(8'(i));

    idle(8'd10);
    idle(8'd11);
    idle(8'd12);
    for (int i = 0; i < 5; i++)
      cyc(8'($urandom), 0, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
          i == 2, 8'd40, 16'h4444);

    async_reset_check();
    reset = 1'b1;
    idle(8'd40);
    idle(8'd41);
    idle(8'd42);
    idle(8'd43);

    chk("sb_drained", 32'(q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
